// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration register bank.
package spi_cfg_pkg;

   typedef enum logic [1:0] {StIdle, StHdr, StData, StOvf} rx_state_e;

   localparam logic RwWrite = 1'b1;
   localparam logic RwRead  = 1'b0;

   function automatic int unsigned frame_len(int unsigned addr_w, int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: bit counter, header/data deserializer and frame FSM.
module spi_frame_rx
   import spi_cfg_pkg::*;
#(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 8,
   localparam int unsigned FrameLen = frame_len(ADDR_W, DATA_W),
   localparam int unsigned CntW = $clog2(FrameLen + 1)
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              cs_b,
   input  logic              sdi,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] shadow,
   output logic [CntW-1:0]   cnt,
   output logic              ovf,
   output logic              frame_end,
   output logic              rd_load,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              data_shift
);

   localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);
   localparam logic [CntW-1:0] CntHdr  = CntW'(1 + ADDR_W);

   rx_state_e         state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   hdr_q, hdr_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic              cs_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      shadow_d  = shadow_q;
      frame_end = cs_b && !cs_q;
      if (frame_end) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (!cs_b) begin
         unique case (state_q)
            StIdle: begin
               hdr_d    = {{ADDR_W{1'b0}}, sdi};
               shadow_d = '0;
               cnt_d    = CntW'(1);
               state_d  = StHdr;
            end
            StHdr: begin
               hdr_d = {hdr_q[ADDR_W-1:0], sdi};
               cnt_d = cnt_q + CntW'(1);
               if (cnt_d == CntHdr) state_d = StData;
            end
            StData: begin
               // A bit beyond the full frame length poisons the frame.
               if (cnt_q == CntFull) begin
                  state_d = StOvf;
               end else begin
                  shadow_d = {shadow_q[DATA_W-2:0], sdi};
                  cnt_d    = cnt_q + CntW'(1);
               end
            end
            StOvf: ;
            default: state_d = StIdle;
         endcase
      end
      rd_load    = !cs_b && (state_q == StHdr) && (cnt_d == CntHdr) && (hdr_d[ADDR_W] == RwRead);
      data_shift = !cs_b && (state_q == StData) && (cnt_q != CntFull);
   end

   assign rw      = hdr_q[ADDR_W];
   assign addr    = hdr_q[ADDR_W-1:0];
   assign rd_addr = hdr_d[ADDR_W-1:0];
   assign shadow  = shadow_q;
   assign cnt     = cnt_q;
   assign ovf     = (state_q == StOvf);

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         hdr_q    <= '0;
         shadow_q <= '0;
         cs_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hdr_q    <= hdr_d;
         shadow_q <= shadow_d;
         cs_q     <= cs_b;
      end
   end

endmodule

// File: rtl/spi_cfg_regbank.sv
// Addressable SPI configuration register bank with atomic commit and serial readback.
module spi_cfg_regbank
   import spi_cfg_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned NUM_REGS = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       sclk,
   input  logic                       rst,
   input  logic                       cs_b,
   input  logic                       sdi,
   output logic                       sdo,
   output logic [NUM_REGS*DATA_W-1:0] cfg,
   output logic [NUM_REGS-1:0]        cfg_update,
   output logic                       frame_err
);

   localparam int unsigned FrameLen = frame_len(ADDR_W, DATA_W);
   localparam int unsigned CntW = $clog2(FrameLen + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FrameLen);

   logic              rw, ovf, frame_end, rd_load, data_shift, len_ok;
   logic [ADDR_W-1:0] addr, rd_addr;
   logic [DATA_W-1:0] shadow;
   logic [CntW-1:0]   cnt;

   logic [NUM_REGS-1:0][DATA_W-1:0] cfg_q, cfg_d;
   logic [NUM_REGS-1:0]             upd_q, upd_d;
   logic [DATA_W-1:0]               rd_q, rd_d;
   logic                            err_q, err_d, sdo_q, sdo_d;

   spi_frame_rx #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rx (
      .sclk       (sclk),
      .rst        (rst),
      .cs_b       (cs_b),
      .sdi        (sdi),
      .rw         (rw),
      .addr       (addr),
      .shadow     (shadow),
      .cnt        (cnt),
      .ovf        (ovf),
      .frame_end  (frame_end),
      .rd_load    (rd_load),
      .rd_addr    (rd_addr),
      .data_shift (data_shift)
   );

   assign len_ok = (cnt == CntFull) && !ovf;

   always_comb begin
      cfg_d = cfg_q;
      upd_d = '0;
      err_d = 1'b0;
      rd_d  = rd_q;
      sdo_d = 1'b0;
      if (frame_end) begin
         rd_d = '0;
         if (!len_ok) begin
            err_d = 1'b1;
         end else if (rw == RwWrite) begin
            if (int'(addr) >= int'(NUM_REGS)) err_d = 1'b1;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
               if (int'(addr) == i) begin
                  cfg_d[i] = shadow;
                  upd_d[i] = 1'b1;
               end
            end
         end
      end else if (rd_load) begin
         // Unimplemented addresses read back as zero.
         rd_d = '0;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (int'(rd_addr) == i) rd_d = cfg_q[i];
         end
         sdo_d = rd_d[DATA_W-1];
         rd_d  = {rd_d[DATA_W-2:0], 1'b0};
      end else if (data_shift && (rw == RwRead)) begin
         sdo_d = rd_q[DATA_W-1];
         rd_d  = {rd_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         cfg_q <= RESET_VAL;
         upd_q <= '0;
         err_q <= 1'b0;
         rd_q  <= '0;
         sdo_q <= 1'b0;
      end else begin
         cfg_q <= cfg_d;
         upd_q <= upd_d;
         err_q <= err_d;
         rd_q  <= rd_d;
         sdo_q <= sdo_d;
      end
   end

   assign cfg        = cfg_q;
   assign cfg_update = upd_q;
   assign frame_err  = err_q;
   assign sdo        = sdo_q;

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed self-checking bench for spi_cfg_regbank with default parameters.
module tb_spi_cfg_regbank;

   logic        sclk, rst, cs_b, sdi, sdo, frame_err;
   logic [31:0] cfg;
   logic [3:0]  cfg_update;
   int          checks = 0;
   int          errors = 0;

   spi_cfg_regbank dut (
      .sclk       (sclk),
      .rst        (rst),
      .cs_b       (cs_b),
      .sdi        (sdi),
      .sdo        (sdo),
      .cfg        (cfg),
      .cfg_update (cfg_update),
      .frame_err  (frame_err)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [15:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         cs_b = 1'b0;
         sdi  = bits[i];
         step();
      end
   endtask

   task automatic end_frame();
      cs_b = 1'b1;
      sdi  = 1'b0;
      step();
   endtask

   // Read frame: header 0,a1,a0 then 8 dummy bits; sdo bit k follows edge 3+k.
   task automatic read_frame(input logic [1:0] a, input logic [7:0] exp, input string tag);
      logic [10:0] bits;
      bits = {1'b0, a, 8'h00};
      for (int i = 0; i < 11; i++) begin
         cs_b = 1'b0;
         sdi  = bits[10-i];
         step();
         if (i >= 2 && i <= 9) check(tag, {31'd0, sdo}, {31'd0, exp[9-i]});
      end
      end_frame();
      check({tag, "_upd"}, {28'd0, cfg_update}, 32'd0);
      check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_sdo_idle"}, {31'd0, sdo}, 32'd0);
   endtask

   initial begin
      rst  = 1'b1;
      cs_b = 1'b1;
      sdi  = 1'b0;
      step();
      step();
      check("rst_cfg", cfg, 32'd0);
      check("rst_sdo", {31'd0, sdo}, 32'd0);
      check("rst_upd", {28'd0, cfg_update}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      step();

      // Write 0xAC to reg 1
      send_bits(16'b1_01_10101100, 11);
      check("wr1_midframe_cfg", cfg, 32'd0);
      check("wr1_sdo", {31'd0, sdo}, 32'd0);
      end_frame();
      check("wr1_cfg", cfg, 32'h0000AC00);
      check("wr1_upd", {28'd0, cfg_update}, 32'h2);
      check("wr1_err", {31'd0, frame_err}, 32'd0);
      step();
      check("wr1_upd_drop", {28'd0, cfg_update}, 32'd0);

      read_frame(2'd1, 8'hAC, "rd1_sdo");
      check("rd1_cfg", cfg, 32'h0000AC00);

      // Short write (10 bits) to reg 2
      send_bits(16'b1_10_0101001, 10);
      end_frame();
      check("short_err", {31'd0, frame_err}, 32'd1);
      check("short_upd", {28'd0, cfg_update}, 32'd0);
      check("short_cfg", cfg, 32'h0000AC00);
      step();
      check("short_err_drop", {31'd0, frame_err}, 32'd0);

      // Long write (12 bits) to reg 3
      send_bits(16'b1_11_11111111_0, 12);
      end_frame();
      check("long_err", {31'd0, frame_err}, 32'd1);
      check("long_upd", {28'd0, cfg_update}, 32'd0);
      check("long_cfg", cfg, 32'h0000AC00);
      step();
      send_bits(16'b1_11_01010011, 11);
      end_frame();
      check("wr3_cfg", cfg, 32'h5300AC00);
      check("wr3_upd", {28'd0, cfg_update}, 32'h8);
      check("wr3_err", {31'd0, frame_err}, 32'd0);
      step();

      read_frame(2'd3, 8'h53, "rd3_sdo");

      // Reset in the middle of a write to reg 2
      send_bits(16'b1_10_11, 5);
      rst = 1'b1;
      step();
      check("midrst_cfg", cfg, 32'd0);
      check("midrst_upd", {28'd0, cfg_update}, 32'd0);
      check("midrst_err", {31'd0, frame_err}, 32'd0);
      rst  = 1'b0;
      cs_b = 1'b1;
      step();
      check("postrst_upd", {28'd0, cfg_update}, 32'd0);
      check("postrst_err", {31'd0, frame_err}, 32'd0);
      check("postrst_cfg", cfg, 32'd0);

      send_bits(16'b1_00_01011010, 11);
      end_frame();
      check("wr0_cfg", cfg, 32'h0000005A);
      check("wr0_upd", {28'd0, cfg_update}, 32'h1);
      check("wr0_err", {31'd0, frame_err}, 32'd0);
      step();

      read_frame(2'd0, 8'h5A, "rd0_sdo");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
